// File: rtl/sda_kernel_ctrl_regs_pkg.sv
// Shared definitions for the kernel control register block: register byte
// offsets, CTRL bit positions and control FSM state encodings.
package sda_kernel_ctrl_regs_pkg;

  localparam logic [31:0] OFF_CTRL = 32'h00;
  localparam logic [31:0] OFF_GIE  = 32'h04;
  localparam logic [31:0] OFF_IER  = 32'h08;
  localparam logic [31:0] OFF_ISR  = 32'h0C;
  localparam logic [31:0] OFF_ARG0 = 32'h10;

  localparam int CTRL_START = 0;
  localparam int CTRL_DONE  = 1;
  localparam int CTRL_IDLE  = 2;
  localparam int CTRL_AUTO  = 7;

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_GO   = 2'd1;
  localparam logic [1:0] ST_BUSY = 2'd2;

  // True when a word-aligned byte address falls inside the ARG window.
  function automatic logic is_arg_addr(input logic [31:0] addr, input int num_args);
    return (addr[1:0] == 2'b00) && (addr >= OFF_ARG0) &&
           (addr < (OFF_ARG0 + 32'(4 * num_args)));
  endfunction

endpackage

// File: rtl/sda_kernel_ctrl_regs_arg_regs.sv
// Scalar argument register file with a shadow copy that is handed to the
// kernel. Host writes always update the readable copy; the shadow only
// follows it when the control FSM launches the kernel.
module sda_kernel_arg_regs
  import sda_kernel_ctrl_regs_pkg::*;
#(
  parameter int NumArgs = 4,
  parameter int IdxW    = 2
) (
  input  logic                  clk,
  input  logic                  srst,
  input  logic                  wr_en,
  input  logic [IdxW-1:0]       wr_idx,
  input  logic [31:0]           wr_data,
  input  logic [IdxW-1:0]       rd_idx,
  output logic [31:0]           rd_data,
  input  logic                  latch,
  output logic [NumArgs*32-1:0] arg_data
);

  logic [31:0] arg_q [NumArgs];

  // Host-visible argument registers.
  always_ff @(posedge clk) begin
    if (srst) begin
      for (int k = 0; k < NumArgs; k++) arg_q[k] <= '0;
    end else if (wr_en) begin
      arg_q[wr_idx] <= wr_data;
    end
  end

  // Kernel-facing snapshot, captured only at go-accept so BUSY writes cannot
  // disturb a running kernel.
  always_ff @(posedge clk) begin
    if (srst) begin
      arg_data <= '0;
    end else if (latch) begin
      for (int k = 0; k < NumArgs; k++) arg_data[32*k +: 32] <= arg_q[k];
    end
  end

  assign rd_data = arg_q[rd_idx];

endmodule

// File: rtl/sda_kernel_ctrl_regs.sv
// Kernel control register block: host register port (request registered,
// response registered), IDLE/GO/BUSY launch FSM with go/done handshakes and
// latched scalar arguments. Optional interrupt logic (GIE/IER/ISR, irq port)
// is built only when SDA_KERNEL_CTRL_IRQ_EN is defined.
module sda_kernel_ctrl_regs
  import sda_kernel_ctrl_regs_pkg::*;
#(
  parameter int RegAddrWidth = 8,
  parameter int NumArgs      = 4
) (
  input  logic                    clk,
  input  logic                    srst,
  input  logic                    regReq,
  output logic                    regAck,
  input  logic                    regWriteEn,
  input  logic [RegAddrWidth-1:0] regAddr,
  input  logic [31:0]             regWData,
  output logic [31:0]             regRData,
  output logic                    goValid,
  input  logic                    goHoldoff,
  input  logic                    doneValid,
  output logic                    doneStop,
  output logic [NumArgs*32-1:0]   argData
`ifdef SDA_KERNEL_CTRL_IRQ_EN
  ,
  output logic                    irq
`endif
);

  localparam int IdxW = (NumArgs > 1) ? $clog2(NumArgs) : 1;

  logic                    req_p0;
  logic                    we_p0;
  logic [RegAddrWidth-1:0] addr_p0;
  logic [31:0]             wdata_p0;

  logic [31:0]     addr32;
  logic            sel_ctrl;
  logic            sel_arg;
  logic [IdxW-1:0] arg_idx;
  logic            wr;
  logic            ctrl_wr;
  logic            ctrl_rd;
  logic            start_set;

  logic [1:0] state_q;
  logic [1:0] state_d;
  logic       launch;
  logic       complete;

  logic        start_q;
  logic        done_q;
  logic        auto_q;
  logic [31:0] arg_rdata;
  logic [31:0] rdata_d;

  // ---- stage p0: request capture ----
  // Accept a new request only when no earlier one is still in flight.
  always_ff @(posedge clk) begin
    if (srst) req_p0 <= 1'b0;
    else      req_p0 <= regReq & ~req_p0 & ~regAck;
  end

  // Capture the access fields alongside the accepted request.
  always_ff @(posedge clk) begin
    if (regReq & ~req_p0 & ~regAck) begin
      we_p0    <= regWriteEn;
      addr_p0  <= regAddr;
      wdata_p0 <= regWData;
    end
  end

  assign addr32    = 32'(addr_p0);
  assign sel_ctrl  = (addr32 == OFF_CTRL);
  assign sel_arg   = is_arg_addr(addr32, NumArgs);
  assign arg_idx   = IdxW'((addr32 - OFF_ARG0) >> 2);
  assign wr        = req_p0 & we_p0;
  assign ctrl_wr   = wr & sel_ctrl;
  assign ctrl_rd   = req_p0 & ~we_p0 & sel_ctrl;
  assign start_set = ctrl_wr & wdata_p0[CTRL_START];

  // Launch FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: if (start_q)    state_d = ST_GO;
      ST_GO:   if (~goHoldoff) state_d = ST_BUSY;
      ST_BUSY: if (doneValid)  state_d = ST_IDLE;
      default:                 state_d = ST_IDLE;
    endcase
  end

  // Launch FSM state register.
  always_ff @(posedge clk) begin
    if (srst) state_q <= ST_IDLE;
    else      state_q <= state_d;
  end

  assign launch   = (state_q == ST_GO) & ~goHoldoff;
  assign complete = (state_q == ST_BUSY) & doneValid;
  assign goValid  = (state_q == ST_GO);
  assign doneStop = (state_q != ST_BUSY);

  // CTRL bits: start is write-1-to-set and held through a run (auto_restart
  // keeps it set so the FSM relaunches); done is set by completion and
  // cleared by a CTRL read or a start write, completion winning a tie.
  always_ff @(posedge clk) begin
    if (srst) begin
      start_q <= 1'b0;
      done_q  <= 1'b0;
      auto_q  <= 1'b0;
    end else begin
      if (start_set)              start_q <= 1'b1;
      else if (complete & ~auto_q) start_q <= 1'b0;
      if (complete)                  done_q <= 1'b1;
      else if (ctrl_rd | start_set)  done_q <= 1'b0;
      if (ctrl_wr) auto_q <= wdata_p0[CTRL_AUTO];
    end
  end

  sda_kernel_arg_regs #(
    .NumArgs (NumArgs),
    .IdxW    (IdxW)
  ) u_arg_regs (
    .clk      (clk),
    .srst     (srst),
    .wr_en    (wr & sel_arg),
    .wr_idx   (arg_idx),
    .wr_data  (wdata_p0),
    .rd_idx   (arg_idx),
    .rd_data  (arg_rdata),
    .latch    (launch),
    .arg_data (argData)
  );

`ifdef SDA_KERNEL_CTRL_IRQ_EN
  logic sel_gie;
  logic sel_ier;
  logic sel_isr;
  logic gie_q;
  logic ier_q;
  logic isr_q;
  logic irq_q;

  assign sel_gie = (addr32 == OFF_GIE);
  assign sel_ier = (addr32 == OFF_IER);
  assign sel_isr = (addr32 == OFF_ISR);

  // Interrupt enables and status; a completion setting ISR beats a toggle.
  always_ff @(posedge clk) begin
    if (srst) begin
      gie_q <= 1'b0;
      ier_q <= 1'b0;
      isr_q <= 1'b0;
      irq_q <= 1'b0;
    end else begin
      if (wr & sel_gie) gie_q <= wdata_p0[0];
      if (wr & sel_ier) ier_q <= wdata_p0[0];
      if (complete & ier_q)                 isr_q <= 1'b1;
      else if (wr & sel_isr & wdata_p0[0])  isr_q <= ~isr_q;
      irq_q <= gie_q & isr_q;
    end
  end

  assign irq = irq_q;
`endif

  // Read data mux; values are taken before this cycle's register updates.
  always_comb begin
    rdata_d = '0;
    if (sel_ctrl) begin
      rdata_d[CTRL_START] = start_q;
      rdata_d[CTRL_DONE]  = done_q;
      rdata_d[CTRL_IDLE]  = (state_q == ST_IDLE);
      rdata_d[CTRL_AUTO]  = auto_q;
    end
`ifdef SDA_KERNEL_CTRL_IRQ_EN
    if (sel_gie) rdata_d[0] = gie_q;
    if (sel_ier) rdata_d[0] = ier_q;
    if (sel_isr) rdata_d[0] = isr_q;
`endif
    if (sel_arg) rdata_d = arg_rdata;
  end

  // ---- stage p1: registered response ----
  // One-cycle ack; read data is zero except on an acked read.
  always_ff @(posedge clk) begin
    if (srst) begin
      regAck   <= 1'b0;
      regRData <= '0;
    end else begin
      regAck   <= req_p0;
      regRData <= (req_p0 & ~we_p0) ? rdata_d : '0;
    end
  end

endmodule

// File: tb/tb_sda_kernel_ctrl_regs.sv
// Directed bench for sda_kernel_ctrl_regs: a table of register accesses
// followed by hand-written launch/complete/reset sequences. Interrupt checks
// are compiled in when SDA_KERNEL_CTRL_IRQ_EN is defined.
module tb_sda_kernel_ctrl_regs;

  logic         clk;
  logic         srst;
  logic         regReq;
  logic         regAck;
  logic         regWriteEn;
  logic [7:0]   regAddr;
  logic [31:0]  regWData;
  logic [31:0]  regRData;
  logic         goValid;
  logic         goHoldoff;
  logic         doneValid;
  logic         doneStop;
  logic [127:0] argData;
`ifdef SDA_KERNEL_CTRL_IRQ_EN
  logic         irq;
  localparam logic [31:0] IRQ_RB = 32'h1;
`else
  localparam logic [31:0] IRQ_RB = 32'h0;
`endif

  int nvec;
  int nfail;

  sda_kernel_ctrl_regs #(.RegAddrWidth(8), .NumArgs(4)) dut (
    .clk        (clk),
    .srst       (srst),
    .regReq     (regReq),
    .regAck     (regAck),
    .regWriteEn (regWriteEn),
    .regAddr    (regAddr),
    .regWData   (regWData),
    .regRData   (regRData),
    .goValid    (goValid),
    .goHoldoff  (goHoldoff),
    .doneValid  (doneValid),
    .doneStop   (doneStop),
    .argData    (argData)
`ifdef SDA_KERNEL_CTRL_IRQ_EN
    ,
    .irq        (irq)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // One host access; returns on the negedge where regAck is seen.
  task automatic access(input logic we, input logic [7:0] a, input logic [31:0] d,
                        output logic [31:0] rd);
    int n;
    @(negedge clk);
    regReq = 1'b1; regWriteEn = we; regAddr = a; regWData = d;
    @(negedge clk);
    regReq = 1'b0;
    n = 0;
    while (!regAck && n < 10) begin
      @(negedge clk);
      n++;
    end
    if (!regAck) begin
      nvec++;
      nfail++;
      $display("FAIL ack_timeout: addr %0h no ack after %0d cycles", a, n);
    end else begin
      check("ack_latency", 128'(n), 128'd1);
    end
    rd = regRData;
  endtask

  task automatic wr(input logic [7:0] a, input logic [31:0] d);
    logic [31:0] rd;
    access(1'b1, a, d, rd);
  endtask

  task automatic rd_check(input string name, input logic [7:0] a, input logic [31:0] exp);
    logic [31:0] rd;
    access(1'b0, a, 32'h0, rd);
    check(name, 128'(rd), 128'(exp));
  endtask

  task automatic done_pulse();
    @(negedge clk);
    doneValid = 1'b1;
    @(negedge clk);
    doneValid = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [7:0]  addr;
    logic [31:0] wdata;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl [20];

  initial begin
    logic [31:0] rd;
    nvec = 0;
    nfail = 0;
    srst = 1'b1; regReq = 1'b0; regWriteEn = 1'b0; regAddr = '0; regWData = '0;
    goHoldoff = 1'b0; doneValid = 1'b0;

    tbl[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 32'h0};
    tbl[1]  = '{1'b1, 8'h14, 32'h12345678, 32'h0};
    tbl[2]  = '{1'b1, 8'h18, 32'hA5A5A5A5, 32'h0};
    tbl[3]  = '{1'b1, 8'h1C, 32'h0000FFFF, 32'h0};
    tbl[4]  = '{1'b0, 8'h10, 32'h0, 32'hDEADBEEF};
    tbl[5]  = '{1'b0, 8'h14, 32'h0, 32'h12345678};
    tbl[6]  = '{1'b0, 8'h18, 32'h0, 32'hA5A5A5A5};
    tbl[7]  = '{1'b0, 8'h1C, 32'h0, 32'h0000FFFF};
    tbl[8]  = '{1'b1, 8'h40, 32'hFFFFFFFF, 32'h0};
    tbl[9]  = '{1'b0, 8'h40, 32'h0, 32'h0};
    tbl[10] = '{1'b0, 8'h11, 32'h0, 32'h0};
    tbl[11] = '{1'b1, 8'h00, 32'h00000006, 32'h0};
    tbl[12] = '{1'b0, 8'h00, 32'h0, 32'h00000004};
    tbl[13] = '{1'b1, 8'h04, 32'h00000001, 32'h0};
    tbl[14] = '{1'b0, 8'h04, 32'h0, IRQ_RB};
    tbl[15] = '{1'b1, 8'h04, 32'h00000000, 32'h0};
    tbl[16] = '{1'b1, 8'h08, 32'h00000001, 32'h0};
    tbl[17] = '{1'b0, 8'h08, 32'h0, IRQ_RB};
    tbl[18] = '{1'b1, 8'h08, 32'h00000000, 32'h0};
    tbl[19] = '{1'b0, 8'hFC, 32'h0, 32'h0};

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_goValid", 128'(goValid), 128'd0);
    check("rst_regAck", 128'(regAck), 128'd0);
    check("rst_regRData", 128'(regRData), 128'd0);
    check("rst_argData", argData, 128'd0);
    check("rst_doneStop", 128'(doneStop), 128'd1);
    srst = 1'b0;
    rd_check("rst_ctrl", 8'h00, 32'h4);

    // Register table
    for (int i = 0; i < 20; i++) begin
      access(tbl[i].we, tbl[i].addr, tbl[i].wdata, rd);
      check($sformatf("tbl%0d", i), 128'(rd), 128'(tbl[i].exp));
    end
    check("arg_not_latched", argData, 128'd0);

    // Launch with immediate accept
    wr(8'h00, 32'h1);
    check("go_not_yet", 128'(goValid), 128'd0);
    @(negedge clk);
    check("go_valid", 128'(goValid), 128'd1);
    check("ack_single", 128'(regAck), 128'd0);
    @(negedge clk);
    check("go_accepted", 128'(goValid), 128'd0);
    check("busy_doneStop", 128'(doneStop), 128'd0);
    check("arg_latched", argData,
          {32'h0000FFFF, 32'hA5A5A5A5, 32'h12345678, 32'hDEADBEEF});
    rd_check("ctrl_busy", 8'h00, 32'h1);
    wr(8'h10, 32'h11111111);
    check("arg_busy_hold", 128'(argData[31:0]), 128'hDEADBEEF);
    rd_check("arg_busy_rb", 8'h10, 32'h11111111);
    wr(8'h00, 32'h1);
    @(negedge clk);
    check("no_relaunch", 128'(goValid), 128'd0);
    done_pulse();
    check("done_doneStop", 128'(doneStop), 128'd1);
    rd_check("ctrl_done", 8'h00, 32'h6);
    rd_check("ctrl_done_clr", 8'h00, 32'h4);

    // Holdoff for five cycles
    goHoldoff = 1'b1;
    wr(8'h00, 32'h1);
    @(negedge clk);
    for (int i = 0; i < 5; i++) begin
      check($sformatf("hold_go%0d", i), 128'(goValid), 128'd1);
      check($sformatf("hold_dstop%0d", i), 128'(doneStop), 128'd1);
      @(negedge clk);
    end
    goHoldoff = 1'b0;
    check("hold_go_last", 128'(goValid), 128'd1);
    @(negedge clk);
    check("hold_accept", 128'(goValid), 128'd0);
    check("hold_busy", 128'(doneStop), 128'd0);
    done_pulse();
    rd_check("hold_ctrl_done", 8'h00, 32'h6);
    rd_check("hold_ctrl_clr", 8'h00, 32'h4);

    // Auto restart
    wr(8'h00, 32'h81);
    @(negedge clk);
    check("ar_go", 128'(goValid), 128'd1);
    @(negedge clk);
    check("ar_busy", 128'(goValid), 128'd0);
    rd_check("ar_ctrl", 8'h00, 32'h81);
    done_pulse();
    check("ar_idle_go", 128'(goValid), 128'd0);
    check("ar_idle_dstop", 128'(doneStop), 128'd1);
    @(negedge clk);
    check("ar_relaunch", 128'(goValid), 128'd1);
    @(negedge clk);
    wr(8'h00, 32'h0);
    done_pulse();
    @(negedge clk);
    check("ar_stopped", 128'(goValid), 128'd0);
    rd_check("ar_ctrl_done", 8'h00, 32'h6);
    rd_check("ar_ctrl_clr", 8'h00, 32'h4);

`ifdef SDA_KERNEL_CTRL_IRQ_EN
    // Interrupt
    wr(8'h04, 32'h1);
    wr(8'h08, 32'h1);
    wr(8'h00, 32'h1);
    repeat (2) @(negedge clk);
    check("irq_busy_low", 128'(irq), 128'd0);
    done_pulse();
    @(negedge clk);
    check("irq_set", 128'(irq), 128'd1);
    rd_check("isr_rb", 8'h0C, 32'h1);
    wr(8'h0C, 32'h1);
    @(negedge clk);
    check("irq_clr", 128'(irq), 128'd0);
    rd_check("irq_unmapped", 8'h40, 32'h0);
    rd_check("irq_ctrl_done", 8'h00, 32'h6);
    wr(8'h04, 32'h0);
`endif

    // Reset in the middle of a run
    wr(8'h00, 32'h1);
    repeat (2) @(negedge clk);
    check("mid_busy", 128'(doneStop), 128'd0);
    check("mid_arg", 128'(argData[31:0]), 128'h11111111);
    srst = 1'b1;
    @(negedge clk);
    check("srst_ack", 128'(regAck), 128'd0);
    srst = 1'b0;
    check("srst_go", 128'(goValid), 128'd0);
    check("srst_arg", argData, 128'd0);
    check("srst_dstop", 128'(doneStop), 128'd1);
    check("srst_rdata", 128'(regRData), 128'd0);
    rd_check("srst_ctrl", 8'h00, 32'h4);
    rd_check("srst_arg0", 8'h10, 32'h0);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

endmodule
